// File: rtl/handshake_control_merge.sv
// Round-robin control merge: forwards one valid input token to a data output and
// its index to a select output, holding the grant until both outputs have fired.
module handshake_control_merge #(
  parameter int NUM_INPUTS = 2,
  parameter int WIDTH      = 32,
  localparam int SEL_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  input  logic [NUM_INPUTS-1:0][WIDTH-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic                             idx_valid,
  input  logic                             idx_ready,
  output logic [SEL_WIDTH-1:0]             idx_data
);

  // Handshake rule on every port: a transfer happens in a cycle where valid and
  // ready are both high; a valid producer holds its payload until that cycle.

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] lock_idx_q, lock_idx_d;
  logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                 out_done_q, out_done_d;
  logic                 idx_done_q, idx_done_d;

  logic [SEL_WIDTH-1:0] scan_grant, grant, grant_next;
  logic                 found, locked, have_grant;
  logic                 out_fire, idx_fire, complete;

  // Two passes: first inputs at or above rr_ptr, then the wrapped-around ones.
  always_comb begin
    found      = 1'b0;
    scan_grant = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!found && in_valid[i] && (SEL_WIDTH'(i) >= rr_ptr_q)) begin
        found      = 1'b1;
        scan_grant = SEL_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!found && in_valid[i]) begin
        found      = 1'b1;
        scan_grant = SEL_WIDTH'(i);
      end
    end
  end

  assign locked     = (state_q == LOCKED);
  assign grant      = locked ? lock_idx_q : scan_grant;
  assign grant_next = (grant == SEL_WIDTH'(NUM_INPUTS - 1)) ? '0 : grant + SEL_WIDTH'(1);
  // rst_n gates the outputs so nothing leaks out while reset is held.
  assign have_grant = rst_n & (locked | (|in_valid));

  assign out_valid = have_grant & ~out_done_q;
  assign idx_valid = have_grant & ~idx_done_q;
  assign out_data  = have_grant ? in_data[grant] : '0;
  assign idx_data  = have_grant ? grant : '0;

  assign out_fire = out_valid & out_ready;
  assign idx_fire = idx_valid & idx_ready;
  assign complete = have_grant & (out_done_q | out_fire) & (idx_done_q | idx_fire);

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_ready[i] = complete && (grant == SEL_WIDTH'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    out_done_d = out_done_q;
    idx_done_d = idx_done_q;
    case (state_q)
      IDLE: begin
        if (complete) begin
          rr_ptr_d = grant_next;
        end else if (have_grant) begin
          state_d    = LOCKED;
          lock_idx_d = grant;
          out_done_d = out_fire;
          idx_done_d = idx_fire;
        end
      end
      LOCKED: begin
        if (complete) begin
          state_d    = IDLE;
          out_done_d = 1'b0;
          idx_done_d = 1'b0;
          rr_ptr_d   = grant_next;
        end else begin
          out_done_d = out_done_q | out_fire;
          idx_done_d = idx_done_q | idx_fire;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      out_done_q <= 1'b0;
      idx_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      out_done_q <= out_done_d;
      idx_done_q <= idx_done_d;
    end
  end

endmodule

// File: tb/tb_handshake_control_merge.sv
// Bench for handshake_control_merge: directed scenarios plus randomized traffic
// against a token-level reference model; a 3-input instance covers pointer wrap.
module tb_handshake_control_merge;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]        in_valid, in_ready;
  logic [N-1:0][W-1:0] in_data;
  logic                out_valid, out_ready, idx_valid, idx_ready;
  logic [W-1:0]        out_data;
  logic [1:0]          idx_data;

  logic [2:0]          v3, r3;
  logic [2:0][W-1:0]   d3;
  logic                ov3, iv3;
  logic [W-1:0]        od3;
  logic [1:0]          id3;

  handshake_control_merge #(.NUM_INPUTS(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_data(idx_data)
  );

  handshake_control_merge #(.NUM_INPUTS(3), .WIDTH(W)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v3), .in_ready(r3), .in_data(d3),
    .out_valid(ov3), .out_ready(1'b1), .out_data(od3),
    .idx_valid(iv3), .idx_ready(1'b1), .idx_data(id3)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which token is owed, and which outputs already took it.
  bit         m_locked, m_osent, m_isent;
  int         m_win, m_rr;
  bit         e_have, e_ov, e_iv, e_done;
  int         e_g;
  logic [N-1:0] e_ready;
  logic [W-1:0] e_data;

  task automatic model_reset();
    m_locked = 0; m_osent = 0; m_isent = 0; m_win = 0; m_rr = 0;
  endtask

  task automatic model_eval();
    bit found;
    e_have = m_locked || (in_valid != '0);
    e_g    = 0;
    found  = 0;
    if (m_locked) e_g = m_win;
    else begin
      for (int k = 0; k < N; k++) begin
        if (!found && in_valid[(m_rr + k) % N]) begin
          e_g   = (m_rr + k) % N;
          found = 1;
        end
      end
    end
    e_data = '0;
    for (int i = 0; i < N; i++) if (e_have && i == e_g) e_data = in_data[i];
    e_ov    = e_have && !m_osent;
    e_iv    = e_have && !m_isent;
    e_done  = e_have && (m_osent || (e_ov && out_ready)) && (m_isent || (e_iv && idx_ready));
    e_ready = e_done ? (N'(1) << e_g) : '0;
  endtask

  task automatic model_update();
    if (e_done) begin
      m_locked = 0; m_osent = 0; m_isent = 0;
      m_rr = (e_g + 1) % N;
    end else if (e_have) begin
      m_locked = 1;
      m_win    = e_g;
      m_osent  = m_osent || (e_ov && out_ready);
      m_isent  = m_isent || (e_iv && idx_ready);
    end
  endtask

  // One cycle: sample just after inputs settle, compare, advance, retire consumed inputs.
  task automatic step();
    #1;
    model_eval();
    check("out_valid", out_valid, e_ov);
    check("idx_valid", idx_valid, e_iv);
    check("out_data", out_data, e_data);
    check("idx_data", idx_data, e_have ? e_g : 0);
    check("in_ready", in_ready, e_ready);
    model_update();
    @(negedge clk);
    in_valid = in_valid & ~e_ready;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    model_reset();
    in_valid  = 4'b1011;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b1;
    idx_ready = 1'b1;
    v3        = 3'b111;
    d3        = {8'hC3, 8'hB2, 8'hA1};
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_idx_valid", idx_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    check("rst_idx_data", idx_data, 0);
    check("rst3_valid", {ov3, iv3, r3}, 0);
    repeat (2) @(negedge clk);
    check("rst_hold_valid", {out_valid, idx_valid, in_ready}, 0);
    in_valid = '0;
    v3       = '0;
    rst_n    = 1'b1;
  endtask

  initial begin
    in_valid = '0; in_data = '0; out_ready = 0; idx_ready = 0;
    v3 = '0; d3 = '0;
    do_reset();

    // Single valid input, both outputs ready: zero-latency completion.
    in_valid = 4'b0100; in_data[2] = 8'hAB; out_ready = 1; idx_ready = 1;
    #1;
    check("t1_out_data", out_data, 8'hAB);
    check("t1_idx_data", idx_data, 2);
    check("t1_in_ready", in_ready, 4'b0100);
    step();
    in_valid = 4'b1001; in_data[0] = 8'h10; in_data[3] = 8'h13;
    #1;
    check("t1_rr_next", idx_data, 3);
    step();
    step();

    // All valid: round-robin order 0,1,2,3.
    do_reset();
    in_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    for (int c = 0; c < 4; c++) begin
      in_valid = 4'b1111;
      #1;
      check("t2_idx_seq", idx_data, c);
      check("t2_ready_seq", in_ready, 4'b0001 << c);
      step();
    end

    // Data fires first, index stalls; lock must hold against input 0.
    do_reset();
    in_valid = 4'b0010; in_data[1] = 8'h5A; in_data[0] = 8'h0F; out_ready = 1; idx_ready = 0;
    #1;
    check("t3_c0_out", {out_valid, idx_valid, in_ready}, 6'b11_0000);
    step();
    for (int c = 1; c < 3; c++) begin
      in_valid = in_valid | 4'b0001;
      #1;
      check("t3_hold_valid", {out_valid, idx_valid}, 2'b01);
      check("t3_hold_idx", idx_data, 1);
      check("t3_hold_rdy", in_ready, 0);
      step();
    end
    idx_ready = 1;
    #1;
    check("t3_c3_rdy", in_ready, 4'b0010);
    step();
    step();

    // Index fires first, data stalls for two cycles.
    do_reset();
    in_valid = 4'b0001; in_data[0] = 8'h77; out_ready = 0; idx_ready = 1;
    #1;
    check("t4_c0", {out_valid, idx_valid, in_ready}, 6'b11_0000);
    step();
    #1;
    check("t4_c1", {out_valid, idx_valid, in_ready}, 6'b10_0000);
    step();
    out_ready = 1;
    #1;
    check("t4_c2", {out_valid, idx_valid, in_ready}, 6'b10_0001);
    step();

    // Reset while locked on input 3 with data already sent.
    do_reset();
    in_valid = 4'b1000; in_data[3] = 8'h5C; out_ready = 1; idx_ready = 0;
    step();
    #1;
    check("t5_locked", {out_valid, idx_valid, idx_data}, 4'b01_11);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", {out_valid, idx_valid}, 0);
    check("t5_async_rdy", in_ready, 0);
    check("t5_async_data", {out_data, idx_data}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; idx_ready = 1;
    #1;
    check("t5_reemit", {out_valid, idx_valid, idx_data}, 4'b11_11);
    check("t5_reemit_data", out_data, 8'h5C);
    step();

    // Three inputs: pointer wraps from 2 back to 0.
    do_reset();
    d3 = {8'hC2, 8'hC1, 8'hC0};
    v3 = 3'b010;
    #1;
    check("n3_first", {iv3, id3, r3}, 6'b1_01_010);
    @(negedge clk);
    v3 = 3'b100;
    #1;
    check("n3_second", {iv3, id3, r3}, 6'b1_10_100);
    @(negedge clk);
    v3 = 3'b011;
    #1;
    check("n3_wrap_idx", id3, 0);
    check("n3_wrap_data", od3, 8'hC0);
    @(negedge clk);
    v3 = '0;

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
          in_valid[i] = 1'b1;
          in_data[i]  = W'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      idx_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/handshake_control_merge.md
Name: handshake_control_merge

Overview:
- Arbitrates N handshake inputs. Emits the winning token on a data output and the winner's index on an index output.
- Is the producer that feeds a handshake mux select input: the index output drives the downstream mux's select, so branches re-converge in the dataflow fabric.
- Fair round-robin arbitration. The grant locks until both outputs complete. Eager-fork output semantics: each output completes independently.

Parameters:
- NUM_INPUTS, 2, number of data inputs (>=1)
- WIDTH, 32, data width in bits (>=1)
- SEL_WIDTH (localparam), (NUM_INPUTS>1) ? clog2(NUM_INPUTS) : 1, index width

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  NUM_INPUTS  per-input valid
- in_ready  output  NUM_INPUTS  per-input ready (one-hot or zero)
- in_data  input  NUM_INPUTS x WIDTH  per-input data
- out_valid  output  1  data output valid
- out_ready  input  1  data output ready
- out_data  output  WIDTH  data of granted input
- idx_valid  output  1  index output valid
- idx_ready  input  1  index output ready
- idx_data  output  SEL_WIDTH  index of granted input

Behaviour:
- State registers, all cleared by rst_n low (async):
  - locked = 0
  - lock_idx = 0
  - out_done = 0
  - idx_done = 0
  - rr_ptr = 0
- While rst_n is low, in_ready, out_valid and idx_valid are 0. out_data and idx_data are 0.
- Grant selection:
  - locked=1: grant = lock_idx; other inputs are ignored.
  - locked=0: grant = first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_INPUTS.
  - have_grant = locked OR any in_valid.
- Outputs are combinational, zero latency:
  - out_valid = have_grant & !out_done
  - idx_valid = have_grant & !idx_done
  - out_data = in_data[grant]
  - idx_data = grant
  - With no grant, out_data and idx_data are 0.
- Completion:
  - out_fire = out_valid & out_ready
  - idx_fire = idx_valid & idx_ready
  - complete = have_grant & (out_done | out_fire) & (idx_done | idx_fire)
- in_ready[grant] = complete; all other in_ready bits are 0. The input token is consumed only in the completion cycle.
- State machine:
  - IDLE (locked=0):
    - Grant and complete in the same cycle -> stay IDLE, rr_ptr <= (grant+1) mod NUM_INPUTS.
    - Grant but not complete -> LOCKED: lock_idx <= grant, out_done <= out_fire, idx_done <= idx_fire.
    - No valid input -> no change.
  - LOCKED (locked=1):
    - Complete -> IDLE: clear out_done and idx_done, rr_ptr <= (lock_idx+1) mod NUM_INPUTS.
    - Otherwise -> out_done |= out_fire, idx_done |= idx_fire.
- Each output fires exactly once per token; the done flag suppresses a second valid.
- Upstream must hold in_valid/in_data stable until in_ready; the lock relies on this.
- rr_ptr arithmetic: wrap from NUM_INPUTS-1 to 0. For non-power-of-two NUM_INPUTS, the increment never produces an out-of-range value.
- NUM_INPUTS=1: grant is always 0 and idx_data is always 0; this degenerates to an eager fork of input 0.
- Reset mid-operation: lock and done flags are dropped and the pending token is not consumed. After release, arbitration restarts from rr_ptr=0, so the same token is re-emitted on both outputs.
- No combinational path from in_data to any ready signal. in_ready depends on in_valid, out_ready, idx_ready and state only.

Test Plan:
- NUM_INPUTS=4, in_valid=4'b0100, data[2]=0xAB, both readies 1 -> same cycle: out_data=0xAB, idx_data=2, in_ready=4'b0100; next rr_ptr=3.
- All four valid, readies 1 for 4 cycles from reset -> idx sequence 0,1,2,3, with one in_ready bit per cycle.
- in_valid[1], out_ready=1, idx_ready=0 for 3 cycles:
  - out fires once in cycle 0, then out_valid=0.
  - idx_valid=1 with idx_data=1 held.
  - in_valid[0] raised in cycle 1 does not steal the grant.
  - idx_ready=1 in cycle 3 -> in_ready[1]=1 that cycle.
- Reversed case: idx_ready=1, out_ready=0 for 2 cycles, then out_ready=1 -> idx fires once, out fires in cycle 2 with in_ready asserted the same cycle.
- Locked on input 3 with out_done=1, rst_n pulsed low mid-cycle -> outputs and in_ready drop asynchronously. After release with in_valid[3] still high, both outputs re-emit index 3.
- NUM_INPUTS=3, input 2 served -> rr_ptr wraps to 0. With inputs 0 and 1 valid next, grant=0.
